// File: rtl/peripheral_divn.sv
// Memory-mapped radix-2 restoring divider with registered bus reads and busy/done/dbz status.
// Optional two's-complement mode is compiled in with `define DIV_SIGNED_EN.
module peripheral_divn #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    output logic [WIDTH-1:0]  d_out,
    output logic              irq_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_A    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_B    = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] ADDR_Q    = ADDR_W'(16);
    localparam logic [ADDR_W-1:0] ADDR_R    = ADDR_W'(20);
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(24);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   a_reg, b_reg, q_reg, r_reg;
    logic [WIDTH-1:0]   wb_q, quo_q, rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, dbz_q, zero_q;
    logic               busy_c, start_c, last_c, sgn_c;
    logic [WIDTH:0]     shifted_c, diff_c;
    logic               ge_c;
    logic [WIDTH-1:0]   rem_n_c, quo_n_c, a_mag_c, b_mag_c;
`ifdef DIV_SIGNED_EN
    logic               sgn_q, neg_q_q, neg_r_q;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? WIDTH'(~v + 1'b1) : v;
    endfunction

    assign busy_c  = (state != S_IDLE);
    assign start_c = cs && wr && (addr == ADDR_CTRL) && d_in[0] && !busy_c;
    assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef DIV_SIGNED_EN
    assign sgn_c   = d_in[1];
`else
    assign sgn_c   = 1'b0;
`endif
    assign a_mag_c = mag(a_reg, sgn_c);
    assign b_mag_c = mag(b_reg, sgn_c);

    // One restoring step: shift in next dividend bit, subtract divisor if it fits.
    assign shifted_c = {rem_q, quo_q[WIDTH-1]};
    assign ge_c      = (shifted_c >= {1'b0, wb_q});
    assign diff_c    = shifted_c - {1'b0, wb_q};
    assign rem_n_c   = ge_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
    assign quo_n_c   = {quo_q[WIDTH-2:0], ge_c};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start_c) state_d = S_RUN;
            S_RUN: begin
                if (zero_q) begin
                    state_d = S_IDLE;
                end else if (last_c) begin
`ifdef DIV_SIGNED_EN
                    state_d = sgn_q ? S_FIX : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            wb_q   <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            if (cs && wr && addr == ADDR_A) a_reg <= d_in;
            if (cs && wr && addr == ADDR_B) b_reg <= d_in;
            if (start_c) begin
                // Divide-by-zero keeps raw A in the quotient shifter so R can return it.
                zero_q <= (b_reg == '0);
                quo_q  <= (b_reg == '0) ? a_reg : a_mag_c;
                wb_q   <= b_mag_c;
                rem_q  <= '0;
                cnt_q  <= '0;
                done_q <= 1'b0;
                dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
                sgn_q   <= sgn_c;
                neg_q_q <= sgn_c && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                neg_r_q <= sgn_c && a_reg[WIDTH-1];
`endif
            end else if (state == S_RUN) begin
                if (zero_q) begin
                    q_reg  <= '1;
                    r_reg  <= quo_q;
                    done_q <= 1'b1;
                    dbz_q  <= 1'b1;
                end else begin
                    rem_q <= rem_n_c;
                    quo_q <= quo_n_c;
                    cnt_q <= cnt_q + 1'b1;
`ifdef DIV_SIGNED_EN
                    if (last_c && !sgn_q) begin
`else
                    if (last_c) begin
`endif
                        q_reg  <= quo_n_c;
                        r_reg  <= rem_n_c;
                        done_q <= 1'b1;
                    end
                end
`ifdef DIV_SIGNED_EN
            end else if (state == S_FIX) begin
                q_reg  <= neg_q_q ? WIDTH'(~quo_q + 1'b1) : quo_q;
                r_reg  <= neg_r_q ? WIDTH'(~rem_q + 1'b1) : rem_q;
                done_q <= 1'b1;
`endif
            end
        end
    end

    // Registered read port; holds last value when not reading.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (cs && rd) begin
            case (addr)
                ADDR_A:    d_out <= a_reg;
                ADDR_B:    d_out <= b_reg;
                ADDR_Q:    d_out <= q_reg;
                ADDR_R:    d_out <= r_reg;
                ADDR_STAT: d_out <= WIDTH'({dbz_q, busy_c, done_q});
                default:   d_out <= '0;
            endcase
        end
    end

    assign irq_done = done_q;

endmodule

// File: tb/tb_peripheral_divn.sv
// Directed and randomized bench for peripheral_divn against an arithmetic reference model.
module tb_peripheral_divn;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  d_in;
    logic          cs, rd, wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  d_out;
    logic          irq_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0;

    peripheral_divn #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out), .irq_done(irq_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        logic [W-1:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // Reference: truncating division; B==0 gives all-ones quotient and R=A.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb;
        if (b == '0) begin
            q = '1; r = a;
        end else if (sgn) begin
            sa = $signed(a); sb = $signed(b);
            q = W'(sa / sb); r = W'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    // Expects done to rise exactly at edge e0+lat.
    task automatic wait_done(input string tag, input int lat);
        while (cyc < e0 + lat - 1) tick();
        check({tag, "_early"}, W'(irq_done), W'(0));
        tick();
        check({tag, "_done"}, W'(irq_done), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        logic [W-1:0] eq, er;
        int lat;
        bit s_eff;
`ifdef DIV_SIGNED_EN
        s_eff = sgn;
`else
        s_eff = 1'b0;
`endif
        model(a, b, s_eff, eq, er);
        lat = (b == '0) ? 1 : (s_eff ? W + 1 : W);
        bus_write(AW'(4), a);
        bus_write(AW'(8), b);
        bus_write(AW'(12), W'({sgn, 1'b1}));
        e0 = cyc;
        wait_done(tag, lat);
        read_check({tag, "_q"}, AW'(16), eq);
        read_check({tag, "_r"}, AW'(20), er);
        read_check({tag, "_st"}, AW'(24), (b == '0) ? W'(5) : W'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb, v;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_dout", d_out, W'(0));
        check("rst_irq", W'(irq_done), W'(0));
        read_check("rst_a", AW'(4), W'(0));
        read_check("rst_q", AW'(16), W'(0));
        read_check("rst_st", AW'(24), W'(0));

        // 100/7 with busy observed just after start.
        bus_write(AW'(4), W'(100));
        bus_write(AW'(8), W'(7));
        bus_write(AW'(12), W'(1));
        e0 = cyc;
        read_check("busy_st", AW'(24), W'(2));
        wait_done("t1", W);
        read_check("t1_q", AW'(16), W'(14));
        read_check("t1_r", AW'(20), W'(2));
        read_check("t1_st", AW'(24), W'(1));
        read_check("t1_st_sticky", AW'(24), W'(1));
        tick();
        check("dout_hold", d_out, W'(1));
        read_check("unmapped", AW'(0), W'(0));
        read_check("ctrl_wo", AW'(12), W'(0));

        run_op("dbz", W'(1234), W'(0), 1'b0);
        run_op("max_by_1", W'(16'hFFFF), W'(1), 1'b0);
        run_op("a_lt_b", W'(5), W'(9), 1'b0);

        // Operand rewrite and start while busy must not disturb the in-flight op.
        bus_write(AW'(4), W'(100));
        bus_write(AW'(8), W'(7));
        bus_write(AW'(12), W'(1));
        e0 = cyc;
        bus_write(AW'(4), W'(50));
        tick();
        bus_write(AW'(12), W'(1));
        wait_done("t4", W);
        read_check("t4_q", AW'(16), W'(14));
        read_check("t4_r", AW'(20), W'(2));
        read_check("t4_a", AW'(4), W'(50));

        // Reset mid-operation.
        bus_write(AW'(4), W'(100));
        bus_write(AW'(8), W'(7));
        bus_write(AW'(12), W'(1));
        e0 = cyc;
        while (cyc < e0 + 4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_irq", W'(irq_done), W'(0));
        read_check("t5_st", AW'(24), W'(0));
        read_check("t5_q", AW'(16), W'(0));
        read_check("t5_r", AW'(20), W'(0));
        repeat (W + 2) tick();
        check("t5_no_done", W'(irq_done), W'(0));
        run_op("t5_new", W'(9), W'(3), 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("s_neg", W'(-100), W'(7), 1'b1);
        run_op("s_ovf", W'(16'h8000), W'(16'hFFFF), 1'b1);
        run_op("s_dbz", W'(-5), W'(0), 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            case (i % 4)
                0: rb = W'(0);
                1: rb = W'(1);
                2: rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, 1'(i % 2));
        end

        bus_read(AW'(8), v);
        check("b_readback", v, rb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
